alu_seq: RTL

- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Same 3-bit opcode set, generalised to WIDTH bits. Adds a valid/ready handshake, a status flag set, and multi-bit shifts/rotates executed one bit per cycle.
- Sits between the register-file read stage and writeback. One operation in flight at a time.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result handshake bundle for alu_seq.
// The master drives requests and result acceptance. The slave (the ALU) drives in_ready and the result/flags.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       sel;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             c_out;
   logic             zero;
   logic             neg;
   logic             ovf;

   modport master (
      output in_valid, a, b, sel, c_in, out_ready,
      input  in_ready, out_valid, out, c_out, zero, neg, ovf
   );

   modport slave (
      input  in_valid, a, b, sel, c_in, out_ready,
      output in_ready, out_valid, out, c_out, zero, neg, ovf
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshake and status flags.
// Shifts and rotates run one bit per cycle. Define ALU_SEQ_SAT_EN for unsigned-saturating add/sub.
module alu_seq #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = 3
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   wrk_q, wrk_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic               c_out_q, c_out_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;
   logic               ovf_q, ovf_d;
   logic               out_valid_q, out_valid_d;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   step_val;
   logic               step_bit;
   logic [WIDTH-1:0]   res;
   logic               res_c;
   logic               res_v;
   logic               load;

   assign shamt = bus.b[SHAMT_W-1:0];
   // Bit WIDTH of each extended result is the carry (add) or the borrow (sub).
   assign sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.c_in};
   assign diff  = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.c_in};

   always_comb begin
      step_val = wrk_q;
      step_bit = 1'b0;
      case (op_q)
         2'b00: begin
            step_val = {wrk_q[WIDTH-2:0], 1'b0};
            step_bit = wrk_q[WIDTH-1];
         end
         2'b01: begin
            step_val = {1'b0, wrk_q[WIDTH-1:1]};
            step_bit = wrk_q[0];
         end
         2'b10: begin
            step_val = {wrk_q[WIDTH-2:0], wrk_q[WIDTH-1]};
            step_bit = wrk_q[WIDTH-1];
         end
         default: begin
            step_val = {wrk_q[0], wrk_q[WIDTH-1:1]};
            step_bit = wrk_q[0];
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      wrk_d       = wrk_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      c_out_d     = c_out_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      res         = '0;
      res_c       = 1'b0;
      res_v       = 1'b0;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               case (bus.sel)
                  3'b000: begin
                     load  = 1'b1;
                     res   = sum[WIDTH-1:0];
                     res_c = sum[WIDTH];
                     res_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
`ifdef ALU_SEQ_SAT_EN
                     if (sum[WIDTH]) res = '1;
`endif
                  end
                  3'b001: begin
                     load  = 1'b1;
                     res   = diff[WIDTH-1:0];
                     res_c = diff[WIDTH];
                     res_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
`ifdef ALU_SEQ_SAT_EN
                     if (diff[WIDTH]) res = '0;
`endif
                  end
                  3'b010: begin
                     load = 1'b1;
                     res  = bus.a | bus.b;
                  end
                  3'b011: begin
                     load = 1'b1;
                     res  = bus.a & bus.b;
                  end
                  default: begin
                     // A zero shift amount completes immediately with a unchanged.
                     if (shamt == '0) begin
                        load = 1'b1;
                        res  = bus.a;
                     end else begin
                        wrk_d   = bus.a;
                        cnt_d   = shamt;
                        op_d    = bus.sel[1:0];
                        state_d = SHIFT;
                     end
                  end
               endcase
            end
         end
         SHIFT: begin
            wrk_d = step_val;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               load  = 1'b1;
               res   = step_val;
               res_c = step_bit;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         out_d       = res;
         c_out_d     = res_c;
         ovf_d       = res_v;
         zero_d      = (res == '0);
         neg_d       = res[WIDTH-1];
         out_valid_d = 1'b1;
         state_d     = DONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_q       <= '0;
         wrk_q       <= '0;
         cnt_q       <= '0;
         op_q        <= '0;
         c_out_q     <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         wrk_q       <= wrk_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         c_out_q     <= c_out_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.c_out     = c_out_q;
   assign bus.zero      = zero_q;
   assign bus.neg       = neg_q;
   assign bus.ovf       = ovf_q;
endmodule
